// File: rtl/keypad_pkg.sv
// Shared helpers and event encoding for the keypad matrix scanner.
package keypad_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return r;
  endfunction

  // Key index width, never narrower than one bit.
  function automatic int code_width(input int rows, input int cols);
    int w;
    w = clog2(rows * cols);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is taken only alongside a pop.
module key_evt_fifo
  import keypad_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop_en;
  logic         wr_en;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_en = pop && !empty;
  assign wr_en  = push && (!full || pop_en);
  assign dout   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad controller: per-key debounce, press/release events queued
// behind a valid/ready port with a sticky overflow flag.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int SCAN_DIV   = 1000,
  parameter  int DEB_SCANS  = 4,
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = code_width(ROWS, COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLS-1:0]      line_in,
  output logic [ROWS-1:0]      line_out,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CW-1:0]        evt_code,
  output logic                 evt_press,
  output logic                 evt_overflow,
  input  logic                 ovf_clr
);

  localparam int NK   = ROWS * COLS;
  localparam int DIVW = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
  localparam int RW   = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);
  localparam int DBW  = (clog2(DEB_SCANS + 1) < 1) ? 1 : clog2(DEB_SCANS + 1);

  logic [COLS-1:0] sync_q1;
  logic [COLS-1:0] sync_q2;
  logic [DIVW-1:0] dwell;
  logic [RW-1:0]   row_idx;
  logic [RW-1:0]   next_row;
  logic            sample;
  logic [DBW-1:0]  deb_cnt [NK];
  logic [NK-1:0]   pending;
  logic            pick_vld;
  logic [CW-1:0]   pick_idx;
  logic [NK-1:0]   pick_mask;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            drop;
  logic [CW:0]     fifo_dout;

  assign sample   = (dwell == DIVW'(SCAN_DIV - 1));
  assign next_row = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= '1;
      sync_q2  <= '1;
      dwell    <= '0;
      row_idx  <= '0;
      line_out <= ~(ROWS'(1));
    end else begin
      sync_q1 <= line_in;
      sync_q2 <= sync_q1;
      if (sample) begin
        dwell    <= '0;
        row_idx  <= next_row;
        line_out <= ~(ROWS'(1) << next_row);
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // A bit set by a debounce change overrides the drain of the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state <= '0;
      pending   <= '0;
      for (int k = 0; k < NK; k++) deb_cnt[k] <= '0;
    end else begin
      pending <= pending & ~pick_mask;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (sample && (row_idx == RW'(r))) begin
            if (~sync_q2[c] == key_state[r*COLS+c]) begin
              deb_cnt[r*COLS+c] <= '0;
            end else if ((deb_cnt[r*COLS+c] + 1'b1) == DBW'(DEB_SCANS)) begin
              key_state[r*COLS+c] <= ~sync_q2[c];
              deb_cnt[r*COLS+c]   <= '0;
              pending[r*COLS+c]   <= 1'b1;
            end else begin
              deb_cnt[r*COLS+c] <= deb_cnt[r*COLS+c] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NK - 1; k >= 0; k--) begin
      if (pending[k]) begin
        pick_vld = 1'b1;
        pick_idx = CW'(k);
      end
    end
    pick_mask = pick_vld ? (NK'(1) << pick_idx) : '0;
  end

  assign pop  = evt_valid & evt_ready;
  assign drop = pick_vld & fifo_full & ~pop;

  key_evt_fifo #(
    .W     (CW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pick_vld),
    .din   ({pick_idx, key_state[pick_idx]}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = fifo_dout[CW:1];
  assign evt_press = fifo_dout[0];

  // A drop in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          evt_overflow <= 1'b0;
    else if (drop)    evt_overflow <= 1'b1;
    else if (ovf_clr) evt_overflow <= 1'b0;
  end

endmodule
